sync_fifo_flex: RTL and testbench
=================================

Name: sync_fifo_flex

Overview:
Parametrised successor to the team's single-clock synchronous FIFO. Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a compile-time first-word-fall-through (FWFT) read mode. Sits between producer and consumer datapaths in the same clock domain, where the plain FIFO lacks back-pressure margin or error visibility.

Parameters:
DATA_WIDTH, 8, width of each stored word.
DEPTH, 16, number of entries; must be a power of two and equal 2**ADDR_WIDTH.
ADDR_WIDTH, 4, pointer width; count width is ADDR_WIDTH+1.
AF_THRESH, 12, almost_full asserts when count >= AF_THRESH (1..DEPTH).
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of contents (pointers/count), errors kept.
wr_en  in  1  write request.
din  in  DATA_WIDTH  write data.
rd_en  in  1  read request (FWFT: pop/acknowledge of the head word).
dout  out  DATA_WIDTH  read data.
rd_valid  out  1  dout holds valid data (see Behaviour).
full  out  1  count == DEPTH.
empty  out  1  count == 0.
almost_full  out  1  count >= AF_THRESH.
almost_empty  out  1  count <= AE_THRESH.
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
clr_err  in  1  clears the sticky error flags.
overflow  out  1  sticky: a write was attempted while full.
underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, dout=0, rd_valid=0, full=0, empty=1, almost_empty=1, almost_full=0, overflow=0, underflow=0. Memory contents are not cleared. rst overrides every other input.
- Accepted write: wr_en && !full. Writes mem[wr_ptr] and increments wr_ptr mod DEPTH (natural wrap).
- Accepted read: rd_en && !empty. Increments rd_ptr mod DEPTH.
- Flags are evaluated against the pre-edge state. Writing while full is never accepted, even with a simultaneous read.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
- count: +1 on write only, -1 on read only, unchanged otherwise. All status flags are registered from next-count and change on the same edge as count.
- Standard mode (FWFT=0): on an accepted read, dout <= mem[rd_ptr] at that edge, giving 1-cycle latency. rd_valid is a 1-cycle pulse in the cycle after an accepted read. dout holds its value otherwise.
- FWFT mode (FWFT=1): dout = mem[rd_ptr] continuously, rd_valid = !empty. The head word is visible with no rd_en. rd_en pops it. After a write into an empty FIFO, dout/rd_valid are valid the cycle after the write edge.
- Errors: a write with wr_en && full sets overflow; the data is dropped and the state is unchanged. A read with rd_en && empty sets underflow; dout is unchanged and rd_valid is not asserted. Both flags are sticky until clr_err or rst. If clr_err coincides with a new error, the set wins.
- flush: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0. wr_en/rd_en in the same cycle are ignored and do not set error flags. dout and sticky errors are retained.
- Parameter sanity: elaboration-time check that DEPTH == 2**ADDR_WIDTH, AF_THRESH in 1..DEPTH, AE_THRESH < DEPTH.

Decomposition:
- Shared package fifo_pkg: clog2-style helper function and the count-width constant rule (ADDR_WIDTH+1).
- One natural sub-module: fifo_mem_2p, a DEPTH x DATA_WIDTH memory with one synchronous write port and one read port (async read for FWFT, registered for standard). Control, pointers and flags stay in the top.

Test Plan:
- Reset, then write 10,20,30,40 and read 4 (FWFT=0) -> dout 10,20,30,40 one cycle after each rd_en, rd_valid pulses; count 0->4->0; empty=1 at end.
- Write 16 words 50..200, then a 17th write of 210 -> full=1 and almost_full=1 from count 12; overflow=1; reading 16 returns 50..200 in order (210 absent).
- When full, assert wr_en+rd_en together -> read accepted, write rejected, count 15, overflow set. When count=8, assert both together -> count stays 8 and order is preserved across pointer wrap.
- Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, dout unchanged. Then clr_err -> underflow=0. clr_err coincident with a new underflow -> underflow=1.
- FWFT=1 build: write 0xA5 -> next cycle dout=0xA5 and rd_valid=1 with no rd_en; rd_en pops it -> empty=1 and rd_valid=0.
- Fill to count 5, then flush with wr_en=1 -> count=0, empty=1, no write stored, no errors. Assert rst mid-burst -> all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the sync_fifo_flex family: width rules and the per-cycle
// operation encoding used by the occupancy logic.
package fifo_pkg;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Occupancy spans 0..DEPTH, so it needs one bit more than a pointer.
    function automatic int unsigned count_width_f(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

    // Encoding is {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x DATA_WIDTH storage with one synchronous write port and one read port,
// either registered (resettable output register) or asynchronous.
module fifo_mem_2p #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned REG_READ   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    if (REG_READ != 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] rdata_q;
        logic [DATA_WIDTH-1:0] rdata_d;

        // Output register only updates on a read; it holds otherwise.
        always_comb begin
            rdata_d = rdata_q;
            if (re) begin
                rdata_d = mem_q[raddr];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q <= '0;
            end else begin
                rdata_q <= rdata_d;
            end
        end

        assign rdata = rdata_q;
    end else begin : g_async_read
        assign rdata = mem_q[raddr];
    end

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 2,
    parameter int unsigned FWFT       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    input  logic                  clr_err,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CW = count_width_f(ADDR_WIDTH);

    if ((DEPTH != (1 << ADDR_WIDTH)) || (clog2_f(DEPTH) != ADDR_WIDTH)) begin : g_bad_depth
        $error("sync_fifo_flex: DEPTH must equal 2**ADDR_WIDTH");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("sync_fifo_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH >= DEPTH) begin : g_bad_ae
        $error("sync_fifo_flex: AE_THRESH must be below DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_acc;
    logic                  rd_acc;
    fifo_op_e              op;

    // Next-state: all decisions use the pre-edge flags; flush masks both ports.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q && !clr_err;
        unf_d      = unf_q && !clr_err;

        wr_acc = wr_en && !full_q && !flush;
        rd_acc = rd_en && !empty_q && !flush;
        op     = fifo_op_e'({wr_acc, rd_acc});

        // A new error in the same cycle as clr_err still sets the flag.
        if (wr_en && full_q && !flush) begin
            ovf_d = 1'b1;
        end
        if (rd_en && empty_q && !flush) begin
            unf_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case (op)
                OP_WR:   count_d = count_q + CW'(1);
                OP_RD:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CW'(AF_THRESH));
        ae_d    = (count_d <= CW'(AE_THRESH));

        // FWFT: head word is valid whenever the FIFO holds data.
        if (FWFT != 0) begin
            rd_valid_d = !empty_d;
        end else begin
            rd_valid_d = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .REG_READ   ((FWFT != 0) ? 0 : 1)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (dout)
    );

    assign rd_valid     = rd_valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: a standard-read and an FWFT instance share
// the same stimulus; expected values are hand-computed constants.
module tb_sync_fifo_flex;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_af, f_af, s_ae, f_ae;
    logic [AW:0]   s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
                     .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(s_dout), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_count), .clr_err(clr_err), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
                     .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din),
        .rd_en(rd_en), .dout(f_dout), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .clr_err(clr_err), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; sample point is 1ns after the edge.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                       input logic c = 1'b0, input logic f = 1'b0, input logic rs = 1'b0);
        wr_en = w; din = d; rd_en = r; clr_err = c; flush = f; rst = rs;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] exp_q[$];

        // Reset state
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_count", 32'(s_count), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_ae", 32'(s_ae), 1);
        chk("rst_af", 32'(s_af), 0);
        chk("rst_ovf", 32'(s_ovf), 0);
        chk("rst_unf", 32'(s_unf), 0);
        chk("rst_rd_valid", 32'(s_rd_valid), 0);
        chk("rst_dout", 32'(s_dout), 0);
        chk("rst_f_rd_valid", 32'(f_rd_valid), 0);

        // Basic write 4 / read 4
        cyc(1'b1, 8'd10, 1'b0);
        cyc(1'b1, 8'd20, 1'b0);
        chk("ae_at_2", 32'(s_ae), 1);
        cyc(1'b1, 8'd30, 1'b0);
        chk("ae_at_3", 32'(s_ae), 0);
        cyc(1'b1, 8'd40, 1'b0);
        chk("count_4", 32'(s_count), 4);
        chk("rd_valid_idle", 32'(s_rd_valid), 0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("basic_dout", 32'(s_dout), 32'(10 * (i + 1)));
            chk("basic_rd_valid", 32'(s_rd_valid), 1);
            chk("basic_count", 32'(s_count), 32'(3 - i));
        end
        cyc(1'b0, '0, 1'b0);
        chk("rd_valid_pulse_end", 32'(s_rd_valid), 0);
        chk("dout_hold", 32'(s_dout), 40);
        chk("basic_empty", 32'(s_empty), 1);

        // Fill to full with 50..200, then an overflowing write of 210
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(50 + 10 * i), 1'b0);
            if (i == 10) chk("af_at_11", 32'(s_af), 0);
            if (i == 11) chk("af_at_12", 32'(s_af), 1);
        end
        chk("full_16", 32'(s_full), 1);
        chk("count_16", 32'(s_count), 16);
        chk("ovf_before", 32'(s_ovf), 0);
        cyc(1'b1, 8'd210, 1'b0);
        chk("ovf_set", 32'(s_ovf), 1);
        chk("count_after_ovf", 32'(s_count), 16);

        // Write+read while full: read wins, write rejected and flagged
        cyc(1'b1, 8'd99, 1'b1);
        chk("full_wr_rd_dout", 32'(s_dout), 50);
        chk("full_wr_rd_count", 32'(s_count), 15);
        chk("full_wr_rd_full", 32'(s_full), 0);
        chk("full_wr_rd_ovf", 32'(s_ovf), 1);
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("drain_to_8", 32'(s_dout), 32'(60 + 10 * i));
        end
        chk("count_8", 32'(s_count), 8);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_cleared", 32'(s_ovf), 0);

        // Simultaneous write+read at count 8 across the pointer wrap
        cyc(1'b1, 8'd211, 1'b1);
        chk("both_dout0", 32'(s_dout), 130);
        chk("both_count", 32'(s_count), 8);
        cyc(1'b1, 8'd212, 1'b1);
        chk("both_dout1", 32'(s_dout), 140);
        cyc(1'b1, 8'd213, 1'b1);
        chk("both_dout2", 32'(s_dout), 150);
        chk("both_count_end", 32'(s_count), 8);
        exp_q = '{8'd160, 8'd170, 8'd180, 8'd190, 8'd200, 8'd211, 8'd212, 8'd213};
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("wrap_order", 32'(s_dout), 32'(exp_q[i]));
        end
        chk("wrap_empty", 32'(s_empty), 1);

        // Underflow, clear, and clear coincident with a new underflow
        cyc(1'b0, '0, 1'b1);
        chk("unf_set", 32'(s_unf), 1);
        chk("unf_rd_valid", 32'(s_rd_valid), 0);
        chk("unf_dout_hold", 32'(s_dout), 213);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("unf_cleared", 32'(s_unf), 0);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("unf_set_wins", 32'(s_unf), 1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Flush with concurrent write/read requests
        for (int i = 1; i <= 5; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
        end
        chk("pre_flush_count", 32'(s_count), 5);
        cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 32'(s_count), 0);
        chk("flush_empty", 32'(s_empty), 1);
        chk("flush_ae", 32'(s_ae), 1);
        chk("flush_dout_kept", 32'(s_dout), 213);
        chk("flush_ovf", 32'(s_ovf), 0);
        cyc(1'b1, 8'h66, 1'b1, 1'b0, 1'b1);
        chk("flush_empty_no_unf", 32'(s_unf), 0);
        chk("flush_empty_count", 32'(s_count), 0);
        cyc(1'b1, 8'h33, 1'b0);
        chk("post_flush_count", 32'(s_count), 1);
        cyc(1'b0, '0, 1'b1);
        chk("post_flush_dout", 32'(s_dout), 32'h33);
        chk("post_flush_rd_valid", 32'(s_rd_valid), 1);

        // Reset in the middle of traffic
        cyc(1'b1, 8'h44, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        cyc(1'b0, '0, 1'b1);
        chk("pre_rst_dout", 32'(s_dout), 32'h44);
        cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("mid_rst_count", 32'(s_count), 0);
        chk("mid_rst_empty", 32'(s_empty), 1);
        chk("mid_rst_dout", 32'(s_dout), 0);
        chk("mid_rst_rd_valid", 32'(s_rd_valid), 0);
        chk("mid_rst_ae", 32'(s_ae), 1);
        chk("mid_rst_f_count", 32'(f_count), 0);
        chk("mid_rst_f_rd_valid", 32'(f_rd_valid), 0);

        // First-word-fall-through instance
        cyc(1'b1, 8'hA5, 1'b0);
        chk("fwft_dout", 32'(f_dout), 32'hA5);
        chk("fwft_rd_valid", 32'(f_rd_valid), 1);
        chk("fwft_count", 32'(f_count), 1);
        chk("std_no_valid", 32'(s_rd_valid), 0);
        cyc(1'b0, '0, 1'b0);
        chk("fwft_hold", 32'(f_dout), 32'hA5);
        chk("fwft_hold_valid", 32'(f_rd_valid), 1);
        cyc(1'b0, '0, 1'b1);
        chk("fwft_pop_empty", 32'(f_empty), 1);
        chk("fwft_pop_valid", 32'(f_rd_valid), 0);
        chk("std_pop_dout", 32'(s_dout), 32'hA5);
        chk("std_pop_valid", 32'(s_rd_valid), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
